// File: rtl/rib_arbiter_if.sv
// RIB arbiter bus bundle: the three master ports plus the single slave channel.
// The arbiter uses the slave view; the masters/peripheral side uses the master view.
interface rib_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [2:0]          m_req_i;
  logic [2:0]          m_we_i;
  logic [3*ADDR_W-1:0] m_addr_i;
  logic [3*DATA_W-1:0] m_wdata_i;
  logic [DATA_W-1:0]   m_rdata_o;
  logic [2:0]          m_ack_o;
  logic [2:0]          m_err_o;
  logic                s_req_o;
  logic                s_we_o;
  logic [ADDR_W-1:0]   s_addr_o;
  logic [DATA_W-1:0]   s_wdata_o;
  logic [DATA_W-1:0]   s_rdata_i;
  logic                s_ack_i;
  logic                rib_hold_flag_o;
  logic [2:0]          grant_o;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i, s_ack_i,
    output m_rdata_o, m_ack_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
           rib_hold_flag_o, grant_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_rdata_i, s_ack_i,
    input  m_rdata_o, m_ack_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
           rib_hold_flag_o, grant_o
  );
endinterface

// File: rtl/rib_arbiter.sv
// Three-master RIB arbiter: core priority or round-robin, grant held until ack,
// withdrawal, or watchdog error termination.
module rib_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int CORE_PRIO = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rib_arbiter_if.slave  bus
);
  localparam int         NM     = 3;
  localparam logic [7:0] WD_MAX = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                     state, state_nxt;
  logic [NM-1:0]              grant, grant_nxt;
  logic [1:0]                 rr_ptr, rr_ptr_nxt;
  logic [7:0]                 wd_cnt, wd_cnt_nxt;
  logic [1:0]                 gi, sel, scan;
  logic                       found;
  logic [3:0]                 req_x, we_x;
  logic [NM-1:0][ADDR_W-1:0]  addr_v;
  logic [NM-1:0][DATA_W-1:0]  wdata_v;

  logic                       s_req, s_we;
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_wdata, rdata;
  logic [NM-1:0]              ack, err;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Padded to 4 entries so a 2-bit index can never fall off the end.
  assign req_x   = {1'b0, bus.m_req_i};
  assign we_x    = {1'b0, bus.m_we_i};
  assign addr_v  = bus.m_addr_i;
  assign wdata_v = bus.m_wdata_i;

  always_comb begin
    gi = 2'd0;
    for (int n = 0; n < NM; n++)
      if (grant[n]) gi = 2'(n);
  end

  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    scan  = rr_ptr;
    for (int j = 0; j < NM; j++) begin
      if (!found && req_x[scan]) begin
        sel   = scan;
        found = 1'b1;
      end
      scan = inc3(scan);
    end
    if (CORE_PRIO != 0 && bus.m_req_i[0]) sel = 2'd0;
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    wd_cnt_nxt = wd_cnt;
    s_req      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    rdata      = '0;
    ack        = '0;
    err        = '0;
    case (state)
      IDLE: begin
        if (|bus.m_req_i) begin
          grant_nxt  = 3'b001 << sel;
          wd_cnt_nxt = 8'd0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        s_we    = we_x[gi];
        s_addr  = addr_v[gi];
        s_wdata = wdata_v[gi];
        if (!req_x[gi]) begin
          // Master gave up: drop silently, keep fairness pointer where it was.
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (bus.s_ack_i) begin
          s_req      = 1'b1;
          ack[gi]    = 1'b1;
          rdata      = bus.s_rdata_i;
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = inc3(gi);
        end else if (wd_cnt == WD_MAX) begin
          ack[gi]    = 1'b1;
          err[gi]    = 1'b1;
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = inc3(gi);
        end else begin
          s_req = 1'b1;
          if (wd_cnt != 8'hFF) wd_cnt_nxt = wd_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= 2'd0;
      wd_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  assign bus.s_req_o         = s_req;
  assign bus.s_we_o          = s_we;
  assign bus.s_addr_o        = s_addr;
  assign bus.s_wdata_o       = s_wdata;
  assign bus.m_rdata_o       = rdata;
  assign bus.m_ack_o         = ack;
  assign bus.m_err_o         = err;
  assign bus.grant_o         = grant;
  // Gated by reset so the core sees no stall while the block is held in reset.
  assign bus.rib_hold_flag_o = rst_n & bus.m_req_i[0] & ~ack[0];
endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter: a priority instance and a round-robin instance share the
// same master stimulus; a cycle model checks both, directed literals pin key cycles.
module tb_rib_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]         req = '0;
  logic [2:0]         we  = '0;
  logic [2:0][AW-1:0] addr  = '0;
  logic [2:0][DW-1:0] wdata = '0;
  logic [DW-1:0]      rdata_in = '0;
  logic [1:0]         ack_en = 2'b11;
  int total = 0;
  int bad   = 0;

  rib_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  rib_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

  assign if0.m_req_i   = req;   assign if1.m_req_i   = req;
  assign if0.m_we_i    = we;    assign if1.m_we_i    = we;
  assign if0.m_addr_i  = addr;  assign if1.m_addr_i  = addr;
  assign if0.m_wdata_i = wdata; assign if1.m_wdata_i = wdata;
  assign if0.s_rdata_i = rdata_in;
  assign if1.s_rdata_i = rdata_in;
  // Slave answers whenever the granted master is still requesting and acks are enabled.
  assign if0.s_ack_i = ack_en[0] & |(if0.grant_o & req);
  assign if1.s_ack_i = ack_en[1] & |(if1.grant_o & req);

  rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CORE_PRIO(1)) u_prio (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CORE_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [2:0]  a_grant[2], a_ack[2], a_err[2];
  logic        a_sreq[2], a_swe[2], a_hold[2];
  logic [31:0] a_saddr[2], a_swdata[2], a_rdata[2];
  assign a_grant[0] = if0.grant_o;  assign a_grant[1] = if1.grant_o;
  assign a_ack[0]   = if0.m_ack_o;  assign a_ack[1]   = if1.m_ack_o;
  assign a_err[0]   = if0.m_err_o;  assign a_err[1]   = if1.m_err_o;
  assign a_sreq[0]  = if0.s_req_o;  assign a_sreq[1]  = if1.s_req_o;
  assign a_swe[0]   = if0.s_we_o;   assign a_swe[1]   = if1.s_we_o;
  assign a_hold[0]  = if0.rib_hold_flag_o; assign a_hold[1] = if1.rib_hold_flag_o;
  assign a_saddr[0] = if0.s_addr_o; assign a_saddr[1] = if1.s_addr_o;
  assign a_swdata[0]= if0.s_wdata_o; assign a_swdata[1]= if1.s_wdata_o;
  assign a_rdata[0] = if0.m_rdata_o; assign a_rdata[1] = if1.m_rdata_o;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, fairness pointer, cycles waited.
  bit m_busy[2];
  int m_own[2], m_ptr[2], m_cnt[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [2:0]  eg, ea, ee;
      logic        es, ew, eh;
      logic [31:0] ead, ewd, erd;
      int g;
      eg = '0; ea = '0; ee = '0; es = 1'b0; ew = 1'b0; eh = 1'b0;
      ead = '0; ewd = '0; erd = '0;
      if (!rst_n) begin
        m_busy[k] = 1'b0; m_ptr[k] = 0; m_cnt[k] = 0; m_own[k] = 0;
      end else if (!m_busy[k]) begin
        eh = req[0];
        if (req != 3'b000) begin
          if (k == 0 && req[0]) m_own[k] = 0;
          else begin
            for (int j = 2; j >= 0; j--)
              if (req[(m_ptr[k] + j) % 3]) m_own[k] = (m_ptr[k] + j) % 3;
          end
          m_busy[k] = 1'b1;
          m_cnt[k]  = 0;
        end
      end else begin
        g   = m_own[k];
        eg  = 3'(1 << g);
        ew  = we[g];
        ead = addr[g];
        ewd = wdata[g];
        if (!req[g]) begin
          m_busy[k] = 1'b0;
        end else if (ack_en[k]) begin
          es = 1'b1; ea[g] = 1'b1; erd = rdata_in;
          m_busy[k] = 1'b0; m_ptr[k] = (g + 1) % 3;
        end else if (m_cnt[k] == TO) begin
          ea[g] = 1'b1; ee[g] = 1'b1;
          m_busy[k] = 1'b0; m_ptr[k] = (g + 1) % 3;
        end else begin
          es = 1'b1; m_cnt[k]++;
        end
        eh = req[0] & ~ea[0];
      end
      chk($sformatf("m%0d.grant", k),  32'(a_grant[k]), 32'(eg));
      chk($sformatf("m%0d.ack", k),    32'(a_ack[k]),   32'(ea));
      chk($sformatf("m%0d.err", k),    32'(a_err[k]),   32'(ee));
      chk($sformatf("m%0d.s_req", k),  32'(a_sreq[k]),  32'(es));
      chk($sformatf("m%0d.s_we", k),   32'(a_swe[k]),   32'(ew));
      chk($sformatf("m%0d.s_addr", k), a_saddr[k],      ead);
      chk($sformatf("m%0d.s_wdata", k),a_swdata[k],     ewd);
      chk($sformatf("m%0d.rdata", k),  a_rdata[k],      erd);
      chk($sformatf("m%0d.hold", k),   32'(a_hold[k]),  32'(eh));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; we = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [2:0] exp_rr[4];

  initial begin
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
    // Reset state, with the core requesting to show hold stays low in reset.
    req = 3'b001;
    @(negedge clk);
    chk("rst grant", 32'(if0.grant_o), 0);
    chk("rst hold",  32'(if0.rib_hold_flag_o), 0);
    chk("rst sreq",  32'(if1.s_req_o), 0);
    do_reset();

    // Core read
    req = 3'b001; addr[0] = 32'h1000_0000; rdata_in = 32'hDEADBEEF; ack_en = 2'b11;
    @(negedge clk);
    chk("t1 idle grant", 32'(if0.grant_o), 0);
    chk("t1 idle hold",  32'(if0.rib_hold_flag_o), 1);
    tick();
    @(negedge clk);
    chk("t1 grant", 32'(if0.grant_o), 32'h1);
    chk("t1 ack",   32'(if0.m_ack_o), 32'h1);
    chk("t1 rdata", if0.m_rdata_o, 32'hDEADBEEF);
    chk("t1 saddr", if0.s_addr_o, 32'h1000_0000);
    chk("t1 hold",  32'(if0.rib_hold_flag_o), 0);
    tick(); req = '0;
    @(negedge clk);
    chk("t1 after grant", 32'(if0.grant_o), 0);
    tick();

    // Round-robin from rr_ptr=0
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        chk("t2 rr grant", 32'(if1.grant_o), 32'(exp_rr[i/2]));
        chk("t2 prio grant", 32'(if0.grant_o), 32'h1);
      end else chk("t2 rr idle", 32'(if1.grant_o), 0);
      tick();
    end
    req = '0;
    tick();

    // Core priority overriding rr_ptr=2
    do_reset();
    req = 3'b110; ack_en = 2'b00;
    @(negedge clk); chk("t3 c0 grant", 32'(if0.grant_o), 0);
    tick();
    @(negedge clk); chk("t3 c1 grant", 32'(if0.grant_o), 32'h2);
    tick(); req = 3'b111; ack_en = 2'b11;
    @(negedge clk); chk("t3 c2 ack", 32'(if0.m_ack_o), 32'h2);
    tick(); req = 3'b101;
    @(negedge clk); chk("t3 c3 grant", 32'(if0.grant_o), 0);
    tick();
    @(negedge clk); chk("t3 core grant", 32'(if0.grant_o), 32'h1);
    chk("t3 rr grant", 32'(if1.grant_o), 32'h4);
    tick(); req = 3'b100;
    @(negedge clk);
    tick();
    @(negedge clk); chk("t3 m2 grant", 32'(if0.grant_o), 32'h4);
    chk("t3 m2 ack", 32'(if0.m_ack_o), 32'h4);
    tick(); req = '0;
    tick();

    // Watchdog, TIMEOUT=4
    do_reset();
    req = 3'b010; we = 3'b010; addr[1] = 32'h2000_0040; wdata[1] = 32'hCAFE_0001;
    rdata_in = 32'h5555_AAAA; ack_en = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t4 sreq", 32'(if0.s_req_o), 1);
        chk("t4 swe",  32'(if0.s_we_o), 1);
        chk("t4 swdata", if0.s_wdata_o, 32'hCAFE_0001);
      end
      if (i >= 1 && i <= 4) chk("t4 no err", 32'(if0.m_err_o), 0);
      if (i == 5) begin
        chk("t4 ack",   32'(if0.m_ack_o), 32'h2);
        chk("t4 err",   32'(if0.m_err_o), 32'h2);
        chk("t4 err rr",32'(if1.m_err_o), 32'h2);
        chk("t4 sreq0", 32'(if0.s_req_o), 0);
        chk("t4 rdata", if0.m_rdata_o, 0);
      end
      tick();
    end
    req = '0; we = '0;
    @(negedge clk); chk("t4 idle grant", 32'(if0.grant_o), 0);
    tick();

    // Withdrawal keeps rr_ptr (set to 1 first by a master-0 transfer)
    do_reset();
    ack_en = 2'b11; req = 3'b001;
    @(negedge clk); tick();
    @(negedge clk); tick();
    req = 3'b100; ack_en = 2'b00;
    @(negedge clk); tick();
    @(negedge clk); chk("t5 grant", 32'(if1.grant_o), 32'h4);
    tick(); req = 3'b000;
    @(negedge clk);
    chk("t5 sreq", 32'(if1.s_req_o), 0);
    chk("t5 ack",  32'(if1.m_ack_o), 0);
    chk("t5 err",  32'(if1.m_err_o), 0);
    tick();
    @(negedge clk); chk("t5 grant clr", 32'(if1.grant_o), 0);
    tick(); req = 3'b111; ack_en = 2'b11;
    @(negedge clk); tick();
    @(negedge clk); chk("t5 rr after", 32'(if1.grant_o), 32'h2);
    tick(); req = '0;
    tick();

    // Reset mid-transaction at wd_cnt=3
    do_reset();
    req = 3'b010; ack_en = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); tick();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 grant", 32'(if0.grant_o), 0);
    chk("t6 sreq",  32'(if0.s_req_o), 0);
    chk("t6 saddr", if0.s_addr_o, 0);
    chk("t6 rr grant", 32'(if1.grant_o), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; ack_en = 2'b11;
    @(negedge clk); chk("t6 idle", 32'(if0.grant_o), 0);
    tick();
    @(negedge clk);
    chk("t6 regrant", 32'(if0.grant_o), 32'h2);
    chk("t6 ack",     32'(if0.m_ack_o), 32'h2);
    tick(); req = '0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
